// File: rtl/accel_pkg.sv
// Shared types and accelerator register map
// for the accelerator DMA master.
package accel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RESP,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  localparam int BUS_W = 32;

  localparam logic [31:0] ACCEL_BASE  = 32'h8000_5000;
  localparam logic [31:0] CTRL_OFS    = 32'h0000_0000;
  localparam logic [31:0] DATA_IN_OFS = 32'h0000_0004;

endpackage

// File: rtl/accel_dma_master_if.sv
// Host bus request/grant/response bundle
// between the DMA master and the memory fabric.
interface accel_dma_master_if;

  logic        host_req_o;
  logic [31:0] host_add_o;
  logic        host_we_o;
  logic [31:0] host_wdata_o;
  logic [3:0]  host_be_o;
  logic        host_gnt_i;
  logic        host_r_valid_i;
  logic [31:0] host_r_rdata_i;

  modport master (
    output host_req_o,
    output host_add_o,
    output host_we_o,
    output host_wdata_o,
    output host_be_o,
    input  host_gnt_i,
    input  host_r_valid_i,
    input  host_r_rdata_i
  );

  modport slave (
    input  host_req_o,
    input  host_add_o,
    input  host_we_o,
    input  host_wdata_o,
    input  host_be_o,
    output host_gnt_i,
    output host_r_valid_i,
    output host_r_rdata_i
  );

endinterface

// File: rtl/accel_dma_master.sv
// Word-at-a-time DMA mover: memory reads feed
// accelerator register writes, one txn in flight.
module accel_dma_master
  import accel_pkg::*;
#(
  parameter int BusWidth = BUS_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] cfg_src_i,
  input  logic [31:0] cfg_dst_i,
  input  logic [15:0] cfg_len_i,
  input  logic        cfg_dst_inc_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        aborted_o,
  accel_dma_master_if.master host
);

  localparam logic [BusWidth-1:0] WORD = 4;

  state_t state_q, state_d;

  logic [BusWidth-1:0] src_q;
  logic [BusWidth-1:0] dst_q;
  logic [BusWidth-1:0] buf_q;
  logic [15:0]         rem_q;
  logic                inc_q;
  logic                abt_q;

  logic rvalid;
  logic gnt;
  logic stop;

  assign rvalid = host.host_r_valid_i;
  assign gnt    = host.host_gnt_i;
  // abort seen at any point in a txn ends the run once it completes
  assign stop   = abort_i | abt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i)
          state_d = (cfg_len_i == '0) ? DONE : RD_REQ;
      end
      RD_REQ: begin
        if (gnt)          state_d = RD_RESP;
        else if (abort_i) state_d = DONE;
      end
      RD_RESP: begin
        if (rvalid)
          state_d = stop ? DONE : WR_REQ;
      end
      WR_REQ: begin
        if (gnt)          state_d = WR_RESP;
        else if (abort_i) state_d = DONE;
      end
      WR_RESP: begin
        if (rvalid)
          state_d = (stop || rem_q == 16'd1)
                  ? DONE : RD_REQ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      buf_q <= '0;
      rem_q <= '0;
      inc_q <= 1'b0;
      abt_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          abt_q <= 1'b0;
          if (start_i && cfg_len_i != '0) begin
            src_q <= cfg_src_i;
            dst_q <= cfg_dst_i;
            rem_q <= cfg_len_i;
            inc_q <= cfg_dst_inc_i;
          end
        end
        RD_RESP: begin
          if (rvalid) buf_q <= host.host_r_rdata_i;
        end
        WR_RESP: begin
          if (rvalid) begin
            src_q <= src_q + WORD;
            if (inc_q) dst_q <= dst_q + WORD;
            rem_q <= rem_q - 16'd1;
          end
        end
        default: ;
      endcase
      if (abort_i && state_q != IDLE && state_q != DONE)
        abt_q <= 1'b1;
    end
  end

  logic rd_req;
  logic wr_req;

  assign rd_req = (state_q == RD_REQ);
  assign wr_req = (state_q == WR_REQ);

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign aborted_o = done_o & abt_q;

  assign host.host_req_o   = rd_req | wr_req;
  assign host.host_we_o    = wr_req;
  assign host.host_be_o    = (rd_req | wr_req) ? 4'hF : 4'h0;
  assign host.host_wdata_o = wr_req ? buf_q : '0;
  assign host.host_add_o   = rd_req ? src_q
                           : wr_req ? dst_q : '0;

endmodule

// File: tb/tb_accel_dma_master.sv
// Randomized bench for accel_dma_master with a
// responding bus slave and a transaction-list model.
module tb_accel_dma_master;
  import accel_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] add;
    logic [31:0] data;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] cfg_src;
  logic [31:0] cfg_dst;
  logic [15:0] cfg_len;
  logic        cfg_inc;
  logic        abort;
  logic        busy;
  logic        done;
  logic        aborted;

  accel_dma_master_if bus ();

  accel_dma_master dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .cfg_src_i     (cfg_src),
    .cfg_dst_i     (cfg_dst),
    .cfg_len_i     (cfg_len),
    .cfg_dst_inc_i (cfg_inc),
    .abort_i       (abort),
    .busy_o        (busy),
    .done_o        (done),
    .aborted_o     (aborted),
    .host          (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  int gnt_delay  = 0;
  int resp_delay = 1;
  bit noisy      = 0;
  int inj_req    = 0;
  int inj_ack    = 0;
  int pend       = 0;
  int stall      = 0;

  logic        last_we;
  logic [31:0] last_add;
  logic [68:0] held;

  txn_t log_q[$];
  txn_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic build_exp(input logic [31:0] s, input logic [31:0] d,
                           input int n, input logic inc);
    logic [31:0] a;
    logic [31:0] w;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = s + 32'(4 * i);
      w = inc ? d + 32'(4 * i) : d;
      exp_q.push_back('{we: 1'b0, add: a, data: 32'h0});
      exp_q.push_back('{we: 1'b1, add: w, data: mem_rd(a)});
    end
  endtask

  // bus slave: grants after gnt_delay stall cycles, answers resp_delay later
  initial begin : slave
    bus.host_gnt_i     = 1'b0;
    bus.host_r_valid_i = 1'b0;
    bus.host_r_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      bus.host_gnt_i     = 1'b0;
      bus.host_r_valid_i = 1'b0;
      bus.host_r_rdata_i = 32'hDEAD_BEEF;
      if (rst) begin
        pend  = 0;
        stall = 0;
      end else begin
        if (inj_req != inj_ack) begin
          inj_ack            = inj_req;
          bus.host_r_valid_i = 1'b1;
          bus.host_r_rdata_i = 32'hBAD0_0BAD;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.host_r_valid_i = 1'b1;
            bus.host_r_rdata_i = last_we ? 32'hC0FF_EE00
                                         : mem_rd(last_add);
          end
        end
        if (bus.host_req_o) begin
          total_cnt++;
          if (pend != 0)
            $display("FAIL req_outstanding: host_req_o=1 with %0d resp cycles pending, required 0",
                     pend);
          else pass_cnt++;
          if (stall == 0) begin
            held = {bus.host_we_o, bus.host_add_o,
                    bus.host_wdata_o, bus.host_be_o};
          end else begin
            total_cnt++;
            if ({bus.host_we_o, bus.host_add_o,
                 bus.host_wdata_o, bus.host_be_o} !== held)
              $display("FAIL stall_stable: got %h, required %h",
                       {bus.host_we_o, bus.host_add_o,
                        bus.host_wdata_o, bus.host_be_o}, held);
            else pass_cnt++;
          end
          if (stall < gnt_delay) begin
            stall++;
          end else begin
            stall          = 0;
            bus.host_gnt_i = 1'b1;
            last_we        = bus.host_we_o;
            last_add       = bus.host_add_o;
            pend           = resp_delay;
            log_q.push_back('{we: bus.host_we_o, add: bus.host_add_o,
                              data: bus.host_we_o ? bus.host_wdata_o
                                                  : 32'h0});
            if (noisy) begin
              bus.host_r_valid_i = 1'b1;
              bus.host_r_rdata_i = 32'hBAD1_BAD1;
            end
          end
        end else begin
          stall = 0;
        end
      end
    end
  end

  task automatic do_xfer(input logic [31:0] s, input logic [31:0] d,
                         input logic [15:0] n, input logic inc,
                         input int abort_at, input int restart_at,
                         output bit got_done, output bit got_abt,
                         output int cyc);
    logic [31:0] r;
    got_done = 0;
    got_abt  = 0;
    cyc      = 0;
    log_q.delete();
    @(negedge clk);
    cfg_src = s;
    cfg_dst = d;
    cfg_len = n;
    cfg_inc = inc;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    r       = $urandom();
    cfg_src = {r[31:2], 2'b00};
    cfg_dst = ~{r[31:2], 2'b00};
    cfg_len = 16'd7;
    cfg_inc = ~inc;
    for (int c = 0; c < 3000; c++) begin
      start = (restart_at >= 0 && c == restart_at);
      if (abort_at >= 0 && log_q.size() >= abort_at && !bus.host_req_o)
        abort = 1'b1;
      if (done) begin
        got_done = 1;
        got_abt  = aborted;
        break;
      end
      if (busy) cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    total_cnt++;
    if (!got_done)
      $display("FAIL xfer_timeout: done_o not seen, required within 3000 cycles");
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy, done, aborted} !== 3'b000)
      $display("FAIL reset_status: got %b, required 000", {busy, done, aborted});
    else pass_cnt++;
    total_cnt++;
    if ({bus.host_req_o, bus.host_we_o, bus.host_add_o,
         bus.host_wdata_o, bus.host_be_o} !== 70'h0)
      $display("FAIL reset_bus: got %h, required 0",
               {bus.host_req_o, bus.host_we_o, bus.host_add_o,
                bus.host_wdata_o, bus.host_be_o});
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    bit gd, ga;
    int cyc;
    gnt_delay = 0; resp_delay = 1; noisy = 0;
    build_exp(32'h1000, ACCEL_BASE + DATA_IN_OFS, 3, 1'b0);
    do_xfer(32'h1000, ACCEL_BASE + DATA_IN_OFS, 16'd3, 1'b0,
            -1, -1, gd, ga, cyc);
    total_cnt++;
    if (cyc != 12) $display("FAIL stream_cycles: got %0d, required 12", cyc);
    else pass_cnt++;
    total_cnt++;
    if (ga !== 1'b0) $display("FAIL stream_aborted: got %b, required 0", ga);
    else pass_cnt++;
    total_cnt++;
    if (log_q.size() != exp_q.size())
      $display("FAIL stream_count: got %0d, required %0d", log_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) if (i < log_q.size()) begin
      total_cnt++;
      if (log_q[i] !== exp_q[i])
        $display("FAIL stream_txn%0d: got %h, required %h", i, log_q[i], exp_q[i]);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if ({done, busy} !== 2'b00)
      $display("FAIL stream_done_pulse: got done,busy=%b, required 00", {done, busy});
    else pass_cnt++;
  endtask

  task automatic test_stall();
    bit gd, ga;
    int cyc;
    gnt_delay = 5; resp_delay = 1; noisy = 0;
    build_exp(32'h0000_2200, ACCEL_BASE + 32'h40, 2, 1'b1);
    do_xfer(32'h0000_2200, ACCEL_BASE + 32'h40, 16'd2, 1'b1,
            -1, -1, gd, ga, cyc);
    total_cnt++;
    if (log_q.size() != exp_q.size())
      $display("FAIL stall_count: got %0d, required %0d", log_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) if (i < log_q.size()) begin
      total_cnt++;
      if (log_q[i] !== exp_q[i])
        $display("FAIL stall_txn%0d: got %h, required %h", i, log_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cyc != 8 + 4 * 5)
      $display("FAIL stall_cycles: got %0d, required %0d", cyc, 8 + 4 * 5);
    else pass_cnt++;
  endtask

  task automatic test_zero_len();
    bit gd, ga;
    int cyc;
    gnt_delay = 0; resp_delay = 1; noisy = 0;
    do_xfer(32'h3000, ACCEL_BASE, 16'd0, 1'b1, -1, -1, gd, ga, cyc);
    total_cnt++;
    if (cyc != 0) $display("FAIL zero_latency: got %0d busy cycles before done, required 0", cyc);
    else pass_cnt++;
    total_cnt++;
    if (ga !== 1'b0 || log_q.size() != 0)
      $display("FAIL zero_bus: got aborted=%b txns=%0d, required 0/0", ga, log_q.size());
    else pass_cnt++;
  endtask

  task automatic test_abort();
    bit gd, ga;
    int cyc;
    gnt_delay = 0; resp_delay = 3; noisy = 0;
    build_exp(32'h4000, ACCEL_BASE + DATA_IN_OFS, 4, 1'b0);
    do_xfer(32'h4000, ACCEL_BASE + DATA_IN_OFS, 16'd4, 1'b0,
            3, -1, gd, ga, cyc);
    total_cnt++;
    if (ga !== 1'b1) $display("FAIL abort_flag: got %b, required 1", ga);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    total_cnt++;
    if (log_q.size() != 3 || busy !== 1'b0)
      $display("FAIL abort_stop: got txns=%0d busy=%b, required 3/0", log_q.size(), busy);
    else pass_cnt++;
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      total_cnt++;
      if (log_q[i] !== exp_q[i])
        $display("FAIL abort_txn%0d: got %h, required %h", i, log_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_rst_mid();
    bit found, gd, ga;
    int cyc;
    gnt_delay = 50; resp_delay = 1; noisy = 0;
    found = 0;
    @(negedge clk);
    cfg_src = 32'h5000; cfg_dst = ACCEL_BASE; cfg_len = 16'd2; cfg_inc = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.host_req_o && bus.host_we_o) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (!found) $display("FAIL rst_reach_wr: WR_REQ not seen, required within 100 cycles");
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, done, aborted, bus.host_req_o, bus.host_we_o,
         bus.host_add_o, bus.host_wdata_o, bus.host_be_o} !== 73'h0)
      $display("FAIL rst_async: got %h, required 0",
               {busy, done, aborted, bus.host_req_o, bus.host_we_o,
                bus.host_add_o, bus.host_wdata_o, bus.host_be_o});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gnt_delay = 0;
    log_q.delete();
    inj_req++;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || log_q.size() != 0)
      $display("FAIL rst_late_resp: got busy=%b txns=%0d, required 0/0", busy, log_q.size());
    else pass_cnt++;
    build_exp(32'h6000, ACCEL_BASE + 32'h10, 1, 1'b1);
    do_xfer(32'h6000, ACCEL_BASE + 32'h10, 16'd1, 1'b1, -1, -1, gd, ga, cyc);
    total_cnt++;
    if (log_q.size() != 2 || log_q[0] !== exp_q[0] || log_q[1] !== exp_q[1])
      $display("FAIL rst_restart: got %0d txns, required %h %h", log_q.size(),
               exp_q[0], exp_q[1]);
    else pass_cnt++;
  endtask

  task automatic test_busy_start();
    bit gd, ga;
    int cyc;
    gnt_delay = 0; resp_delay = 1; noisy = 0;
    build_exp(32'h7000, ACCEL_BASE + DATA_IN_OFS, 3, 1'b0);
    do_xfer(32'h7000, ACCEL_BASE + DATA_IN_OFS, 16'd3, 1'b0,
            -1, 4, gd, ga, cyc);
    total_cnt++;
    if (cyc != 12) $display("FAIL busy_start_cycles: got %0d, required 12", cyc);
    else pass_cnt++;
    total_cnt++;
    if (log_q.size() != exp_q.size())
      $display("FAIL busy_start_count: got %0d, required %0d", log_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) if (i < log_q.size()) begin
      total_cnt++;
      if (log_q[i] !== exp_q[i])
        $display("FAIL busy_start_txn%0d: got %h, required %h", i, log_q[i], exp_q[i]);
      else pass_cnt++;
    end
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL busy_start_idle: got busy=%b, required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_random();
    bit gd, ga;
    int cyc, n;
    logic [31:0] s, d, r;
    logic inc;
    for (int k = 0; k < 8; k++) begin
      r = $urandom();
      s = {r[31:2], 2'b00};
      r = $urandom();
      d = {r[31:2], 2'b00};
      n = $urandom_range(1, 5);
      inc = 1'($urandom_range(0, 1));
      if (k == 0) begin
        s = 32'hFFFF_FFF8; d = 32'hFFFF_FFFC; n = 3; inc = 1'b1;
      end
      gnt_delay  = $urandom_range(0, 2);
      resp_delay = $urandom_range(1, 3);
      noisy      = 1'($urandom_range(0, 1));
      build_exp(s, d, n, inc);
      do_xfer(s, d, 16'(n), inc, -1, -1, gd, ga, cyc);
      total_cnt++;
      if (ga !== 1'b0 || log_q.size() != exp_q.size())
        $display("FAIL rand%0d_count: got aborted=%b txns=%0d, required 0/%0d",
                 k, ga, log_q.size(), exp_q.size());
      else pass_cnt++;
      foreach (exp_q[i]) if (i < log_q.size()) begin
        total_cnt++;
        if (log_q[i] !== exp_q[i])
          $display("FAIL rand%0d_txn%0d: got %h, required %h", k, i, log_q[i], exp_q[i]);
        else pass_cnt++;
      end
      total_cnt++;
      if (cyc != n * (2 * (gnt_delay + 1) + 2 * resp_delay))
        $display("FAIL rand%0d_cycles: got %0d, required %0d", k, cyc,
                 n * (2 * (gnt_delay + 1) + 2 * resp_delay));
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_src = '0; cfg_dst = '0; cfg_len = '0; cfg_inc = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_zero_len();
    test_abort();
    test_rst_mid();
    test_busy_start();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
